ddr2_axi_warb: RTL

- Two-port round-robin arbiter for the AXI write path (AW, W and B channels) in front of ddr2_ctrl.
- Lets two axi_master-style requesters share the single write slave port of the DDR2 controller.
- A grant is held for a whole transaction, from AW acceptance through the B handshake, so bursts never interleave.
- Also checks that each burst's wlast position matches its awlen.

---
 rtl/ddr2_axi_warb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ddr2_axi_warb.sv
// Two-port round-robin write-path arbiter (AW/W/B) in front of ddr2_ctrl.
// A grant spans AW acceptance through the B handshake; wlast is checked against awlen.
//
// state | meaning
// IDLE  | no owner; arbitrate pending awvalid requests
// ADDR  | AW channel of the granted master routed to the slave
// DATA  | W beats of the granted master routed; beat counter tracks awlen
// RESP  | waiting for the B handshake, then release the grant
module ddr2_axi_warb #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ck,
    input  logic                  rst_n,
    input  logic                  m0_awvalid,
    input  logic                  m1_awvalid,
    output logic                  m0_awready,
    output logic                  m1_awready,
    input  logic [ADDR_WIDTH-1:0] m0_awaddr,
    input  logic [ADDR_WIDTH-1:0] m1_awaddr,
    input  logic [7:0]            m0_awlen,
    input  logic [7:0]            m1_awlen,
    input  logic                  m0_wvalid,
    input  logic                  m1_wvalid,
    output logic                  m0_wready,
    output logic                  m1_wready,
    input  logic                  m0_wlast,
    input  logic                  m1_wlast,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m0_bvalid,
    output logic                  m1_bvalid,
    input  logic                  m0_bready,
    input  logic                  m1_bready,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [ADDR_WIDTH-1:0] s_awaddr,
    output logic [7:0]            s_awlen,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    output logic                  s_wlast,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    output logic                  gnt_busy,
    output logic                  gnt_id,
    output logic                  len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t          state, state_nxt;
    logic            rr_ptr, rr_nxt, gnt_nxt;
    logic [7:0]      cnt_beat, cnt_nxt;

    logic                  g_awvalid, g_wvalid, g_wlast, g_bready;
    logic [ADDR_WIDTH-1:0] g_awaddr;
    logic [7:0]            g_awlen;
    logic [DATA_WIDTH-1:0] g_wdata;

    assign g_awvalid = gnt_id ? m1_awvalid : m0_awvalid;
    assign g_awaddr  = gnt_id ? m1_awaddr  : m0_awaddr;
    assign g_awlen   = gnt_id ? m1_awlen   : m0_awlen;
    assign g_wvalid  = gnt_id ? m1_wvalid  : m0_wvalid;
    assign g_wlast   = gnt_id ? m1_wlast   : m0_wlast;
    assign g_wdata   = gnt_id ? m1_wdata   : m0_wdata;
    assign g_bready  = gnt_id ? m1_bready  : m0_bready;

    assign gnt_busy = (state != IDLE);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            gnt_id   <= 1'b0;
            cnt_beat <= 8'd0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            gnt_id   <= gnt_nxt;
            cnt_beat <= cnt_nxt;
        end
    end

    // Every slave/master output is gated by state, so reset (state forced to IDLE) drops them at once.
    always_comb begin
        state_nxt  = state;
        rr_nxt     = rr_ptr;
        gnt_nxt    = gnt_id;
        cnt_nxt    = cnt_beat;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m1_bvalid  = 1'b0;
        s_awvalid  = 1'b0;
        s_awaddr   = '0;
        s_awlen    = 8'd0;
        s_wvalid   = 1'b0;
        s_wlast    = 1'b0;
        s_wdata    = '0;
        s_bready   = 1'b0;
        len_err    = 1'b0;
        case (state)
            IDLE: begin
                if (m0_awvalid || m1_awvalid) begin
                    gnt_nxt   = (m0_awvalid && m1_awvalid) ? rr_ptr : m1_awvalid;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                s_awvalid  = g_awvalid;
                s_awaddr   = g_awaddr;
                s_awlen    = g_awlen;
                m0_awready = !gnt_id && s_awready;
                m1_awready = gnt_id && s_awready;
                if (g_awvalid && s_awready) begin
                    cnt_nxt   = g_awlen;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                s_wvalid  = g_wvalid;
                s_wdata   = g_wdata;
                s_wlast   = g_wlast;
                m0_wready = !gnt_id && s_wready;
                m1_wready = gnt_id && s_wready;
                if (g_wvalid && s_wready) begin
                    // Saturating count: an overrun burst keeps flagging until wlast shows up.
                    cnt_nxt = (cnt_beat == 8'd0) ? 8'd0 : cnt_beat - 8'd1;
                    if (g_wlast) begin
                        len_err   = (cnt_beat != 8'd0);
                        state_nxt = RESP;
                    end else begin
                        len_err   = (cnt_beat == 8'd0);
                    end
                end
            end
            RESP: begin
                m0_bvalid = !gnt_id && s_bvalid;
                m1_bvalid = gnt_id && s_bvalid;
                s_bready  = g_bready;
                if (s_bvalid && g_bready) begin
                    rr_nxt    = ~gnt_id;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
